spi_io_slave: RTL and testbench
===============================

# spi_io_slave

Parametrised SPI slave for LED/button I/O on the pico-ice40 boards, with all logic in the system clock domain. SCK, MOSI and CS are oversampled and synchronised into `clk_i`. A full frame of `LED_W` bits updates the LED register atomically on CS release. MISO returns a snapshot of button levels plus sticky press flags, and the flags clear once they have been read.

## Interface
- `LED_W`, 8: LED register and frame length in bits; a multiple of 8, range 8..32.
- `BTN_W`, 4: number of buttons; 1..16, with 2*`BTN_W` <= `LED_W`.
- `LED_RST`, 0: reset value of `led_o`, `LED_W` bits.
- `DEB_CYCLES`, 16: debounce length in `clk_i` cycles, 2..65535; used only with the debounce macro.
- `clk_i` input 1: system clock; the only clock.
- `rst_i` input 1: reset, synchronous and active-high.
- `spi_sck_i` input 1: SPI clock, mode 0, asynchronous to `clk_i`.
- `spi_cs_i` input 1: chip select, active-low, asynchronous.
- `spi_mosi_i` input 1: data in, MSB first.
- `spi_miso_o` output 1: data out, MSB first.
- `but_i` input `BTN_W`: buttons, active-high, asynchronous.
- `led_o` output `LED_W`: LED register.
- `irq_o` output 1: OR of all sticky press flags.
- `frame_o` output 1: one-cycle pulse when a valid frame completes.
- `err_o` output 1: one-cycle pulse when a frame has the wrong length.

## Operation
- **Synchronisers:** SCK, CS and MOSI each pass through 2 flops, then an edge-detect register; all three paths have equal depth. `but_i` passes through 2 flops.
- **States:**
  - SKIP is the reset state. It moves to IDLE once synchronised CS is high, so a frame already in progress at reset is ignored.
  - IDLE moves to ACTIVE on a detected CS falling edge.
  - ACTIVE moves back to IDLE on a detected CS rising edge.
- **CS fall (IDLE to ACTIVE):**
  - Snapshot `tx = {pressed, level}` into bits [2*`BTN_W`-1:0], zero-extended to `LED_W`.
  - Clear the bit counter.
  - Drive `spi_miso_o` = tx[`LED_W`-1].
- **SCK rise in ACTIVE:**
  - Shift the MOSI sample into the rx register.
  - Increment the bit counter, saturating at `LED_W`+1.
- **SCK fall in ACTIVE:** shift tx left and drive the new MSB on `spi_miso_o`.
- **CS rise with counter == `LED_W`:**
  - `led_o` <= rx.
  - Pulse `frame_o`.
  - Clear the pressed flags that were set in the snapshot.
- **CS rise with any other count:**
  - `led_o` and the pressed flags are unchanged.
  - Pulse `err_o`.
  - A zero-bit frame (CS toggle only) also counts as an error.
- **Pressed flags:**
  - Flag n is set on a 0→1 transition of debounced level n.
  - If a set and a clear hit the same flag in the same cycle, set wins.
  - A press occurring after the snapshot is never cleared by that frame.
- **SCK edges in IDLE or SKIP** are ignored.
- **`spi_miso_o`** is 0 whenever the block is not in ACTIVE.
- **Reset values:**
  - Outputs: `led_o` = `LED_RST`; `spi_miso_o`, `irq_o`, `frame_o`, `err_o` = 0.
  - Internal: pressed flags 0; levels 0; synchroniser flops 0; state SKIP.

## Timing
- A pin edge becomes a detected edge after 3 `clk_i` cycles.
- `spi_miso_o` changes 4 cycles after a falling SCK edge at the pin, and 4 cycles after CS falls at the pin.
- Requirements on the SPI master:
  - f_clk >= 10 × f_sck.
  - At least 6 `clk_i` cycles between CS fall and the first SCK rise.
  - At least 4 `clk_i` cycles between the last SCK fall and CS rise.
  - CS high for at least 4 `clk_i` cycles between frames.
- `led_o`, `frame_o` and `err_o` update 4 cycles after CS rises at the pin.
- `irq_o` is registered and follows the pressed flags with 1 cycle of latency.
- Without debounce, a button edge reaches its pressed flag in 3 cycles.

## Configuration
- Macro: `SPI_IO_BTN_DEBOUNCE_EN`.
- **Defined:**
  - Each button has a counter of width $clog2(`DEB_CYCLES`+1).
  - Level n changes only after the synchronised input has differed from level n for `DEB_CYCLES` consecutive cycles.
  - The counter resets whenever the input matches the level.
- **Undefined:**
  - Level equals the synchronised input.
  - No counters are instantiated.
  - `DEB_CYCLES` is ignored.

## Test plan
Defaults throughout: `LED_W`=8, `BTN_W`=4, `DEB_CYCLES`=16, f_sck = f_clk/16.
1. Reset with CS high, buttons low -> `led_o`=0x00, `spi_miso_o`=0, `irq_o`=0, no `frame_o` or `err_o` pulse.
2. 8-bit frame MOSI=0xA5, buttons idle -> `led_o`=0xA5 exactly 4 cycles after CS rises; one `frame_o` pulse; master reads 0x00.
3. Hold `but_i`[2] high for 40 cycles, release -> `irq_o`=1; next frame reads 0x40; `irq_o`=0 after CS rises; following frame reads 0x00.
4. 5-bit frame, then a 9-bit frame, MOSI=0xFF -> two `err_o` pulses; `led_o` keeps its previous value; pressed flags are retained and reread in the next valid frame.
5. `rst_i` pulsed after 3 bits with CS held low, then the frame finishes and CS rises -> `led_o`=0x00; no `frame_o` or `err_o`; the next 8-bit frame MOSI=0x3C gives `led_o`=0x3C.
6. 10-cycle high glitch on `but_i`[0] -> flag stays 0 with `SPI_IO_BTN_DEBOUNCE_EN` defined; without it the flag sets and the next frame reads 0x10.

Source files
------------

// File: rtl/spi_io_slave.sv
// SPI slave (mode 0) for LED/button I/O: every input is oversampled into clk_i.
// Optional per-button debounce is enabled with `define SPI_IO_BTN_DEBOUNCE_EN.
//
// state  | meaning
// SKIP   | after reset, wait for CS high so a frame already in flight is ignored
// IDLE   | CS high, waiting for a CS falling edge
// ACTIVE | frame in progress, shifting rx/tx on SCK edges
module spi_io_slave #(
    parameter int               LED_W      = 8,
    parameter int               BTN_W      = 4,
    parameter logic [LED_W-1:0] LED_RST    = '0,
    parameter int               DEB_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             spi_sck_i,
    input  logic             spi_cs_i,
    input  logic             spi_mosi_i,
    output logic             spi_miso_o,
    input  logic [BTN_W-1:0] but_i,
    output logic [LED_W-1:0] led_o,
    output logic             irq_o,
    output logic             frame_o,
    output logic             err_o
);

    localparam int CNT_W = $clog2(LED_W + 2);

    typedef enum logic [1:0] {SKIP, IDLE, ACTIVE} state_t;

    generate
        if ((LED_W % 8) != 0 || LED_W < 8 || LED_W > 32) begin : g_bad_led_w
            $error("spi_io_slave: LED_W must be a multiple of 8 in 8..32");
        end
        if (BTN_W < 1 || BTN_W > 16 || 2 * BTN_W > LED_W) begin : g_bad_btn_w
            $error("spi_io_slave: BTN_W must be 1..16 with 2*BTN_W <= LED_W");
        end
        if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb
            $error("spi_io_slave: DEB_CYCLES must be 2..65535");
        end
    endgenerate

    state_t           state;
    logic [2:0]       sck_sync, cs_sync, mosi_sync;
    logic             sck_rise, sck_fall, cs_rise, cs_fall;
    logic [BTN_W-1:0] but_s1, but_s2;
    logic [BTN_W-1:0] level, level_prev, press_set;
    logic [BTN_W-1:0] pressed, snap_pressed, clr_mask;
    logic [LED_W-1:0] snapshot, tx, rx;
    logic [CNT_W-1:0] bit_cnt;

    // Two sync flops, then a third stage that doubles as the edge-detect history;
    // the registered edge pulses line up with mosi_sync[2].
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
            cs_rise   <= 1'b0;
            cs_fall   <= 1'b0;
            but_s1    <= '0;
            but_s2    <= '0;
        end else begin
            sck_sync  <= {sck_sync[1:0], spi_sck_i};
            cs_sync   <= {cs_sync[1:0], spi_cs_i};
            mosi_sync <= {mosi_sync[1:0], spi_mosi_i};
            sck_rise  <= sck_sync[1] & ~sck_sync[2];
            sck_fall  <= ~sck_sync[1] & sck_sync[2];
            cs_rise   <= cs_sync[1] & ~cs_sync[2];
            cs_fall   <= ~cs_sync[1] & cs_sync[2];
            but_s1    <= but_i;
            but_s2    <= but_s1;
        end
    end

`ifdef SPI_IO_BTN_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] deb_cnt [BTN_W];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BTN_W; i++) begin
            if (rst_i) begin
                deb_cnt[i] <= '0;
                level[i]   <= 1'b0;
            end else if (but_s2[i] == level[i]) begin
                deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                deb_cnt[i] <= '0;
                level[i]   <= but_s2[i];
            end else begin
                deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end
`else
    assign level = but_s2;
`endif

    assign press_set = level & ~level_prev;

    always_comb begin
        snapshot                  = '0;
        snapshot[2*BTN_W-1:0]     = {pressed, level};
        clr_mask                  = '0;
        if (state == ACTIVE && cs_rise && bit_cnt == CNT_W'(LED_W))
            clr_mask = snap_pressed;
    end

    // A set in the same cycle as a clear wins because it is OR-ed in last.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_prev <= '0;
            pressed    <= '0;
            irq_o      <= 1'b0;
        end else begin
            level_prev <= level;
            pressed    <= (pressed & ~clr_mask) | press_set;
            irq_o      <= |pressed;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= SKIP;
            led_o        <= LED_RST;
            spi_miso_o   <= 1'b0;
            frame_o      <= 1'b0;
            err_o        <= 1'b0;
            bit_cnt      <= '0;
            rx           <= '0;
            tx           <= '0;
            snap_pressed <= '0;
        end else begin
            frame_o <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                SKIP: begin
                    spi_miso_o <= 1'b0;
                    if (cs_sync[2])
                        state <= IDLE;
                end
                IDLE: begin
                    spi_miso_o <= 1'b0;
                    if (cs_fall) begin
                        state        <= ACTIVE;
                        tx           <= snapshot;
                        snap_pressed <= pressed;
                        bit_cnt      <= '0;
                        spi_miso_o   <= snapshot[LED_W-1];
                    end
                end
                ACTIVE: begin
                    // Presses landing after the snapshot must survive this frame's clear.
                    snap_pressed <= snap_pressed & ~press_set;
                    if (cs_rise) begin
                        state      <= IDLE;
                        spi_miso_o <= 1'b0;
                        if (bit_cnt == CNT_W'(LED_W)) begin
                            led_o   <= rx;
                            frame_o <= 1'b1;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end else begin
                        if (sck_rise) begin
                            rx <= {rx[LED_W-2:0], mosi_sync[2]};
                            if (bit_cnt != CNT_W'(LED_W + 1))
                                bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (sck_fall) begin
                            tx         <= {tx[LED_W-2:0], 1'b0};
                            spi_miso_o <= tx[LED_W-2];
                        end
                    end
                end
                default: begin
                    state      <= SKIP;
                    spi_miso_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_io_slave.sv
// Bench for spi_io_slave: a timeline model of expected outputs, filled in by the
// SPI master / button tasks, is compared against the DUT on every falling clk edge.
module tb_spi_io_slave;

    localparam int LED_W = 8;
    localparam int BTN_W = 4;
    localparam int DEB   = 16;
    localparam int HALF  = 8;
    localparam int MAXC  = 6000;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             spi_sck_i, spi_cs_i, spi_mosi_i;
    logic             spi_miso_o;
    logic [BTN_W-1:0] but_i;
    logic [LED_W-1:0] led_o;
    logic             irq_o, frame_o, err_o;

    always #5 clk = ~clk;

    spi_io_slave #(
        .LED_W(LED_W), .BTN_W(BTN_W), .LED_RST(8'h00), .DEB_CYCLES(DEB)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .spi_sck_i(spi_sck_i), .spi_cs_i(spi_cs_i), .spi_mosi_i(spi_mosi_i),
        .spi_miso_o(spi_miso_o), .but_i(but_i), .led_o(led_o),
        .irq_o(irq_o), .frame_o(frame_o), .err_o(err_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected output timeline, indexed by number of rising clk edges seen.
    logic [7:0] exp_led   [MAXC];
    bit         exp_frame [MAXC];
    bit         exp_err   [MAXC];
    bit         exp_irq   [MAXC];
    bit         exp_mz    [MAXC];
    logic [BTN_W-1:0] m_pressed = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    function automatic void fill_led(input int from, input logic [7:0] v);
        for (int i = from; i < MAXC; i++) exp_led[i] = v;
    endfunction
    function automatic void fill_irq(input int from, input bit v);
        for (int i = from; i < MAXC; i++) exp_irq[i] = v;
    endfunction
    function automatic void fill_mz(input int from, input bit v);
        for (int i = from; i < MAXC; i++) exp_mz[i] = v;
    endfunction

    always @(negedge clk) begin
        if (cyc >= MAXC - 1) begin
            $display("FAIL watchdog at cycle %0d: got no summary, expected finish", cyc);
            $fatal(1, "cycle budget exhausted");
        end
        if (cyc >= 1) begin
            check("led", 32'(led_o), 32'(exp_led[cyc]));
            check("frame", 32'(frame_o), 32'(exp_frame[cyc]));
            check("err", 32'(err_o), 32'(exp_err[cyc]));
            check("irq", 32'(irq_o), 32'(exp_irq[cyc]));
            if (exp_mz[cyc]) check("miso_idle", 32'(spi_miso_o), 0);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b, input int dur);
        int  c;
        bit  takes;
        int  lat;
        c = cyc;
`ifdef SPI_IO_BTN_DEBOUNCE_EN
        takes = (dur >= DEB);
        lat   = 3 + DEB;
`else
        takes = 1'b1;
        lat   = 3;
`endif
        if (takes) begin
            m_pressed[b] = 1'b1;
            fill_irq(c + lat + 1, 1'b1);
        end
        but_i[b] = 1'b1;
        wait_cyc(dur);
        but_i[b] = 1'b0;
    endtask

    // Mode-0 master; rst_bit >= 0 pulses rst_i just before that bit's SCK rise.
    task automatic spi_frame(input int nbits, input logic [31:0] mosi_w, input int rst_bit,
                             output logic [31:0] rd, output int c_rise);
        int               c0;
        logic [BTN_W-1:0] snap_p;
        logic [31:0]      exp_rd;
        bit               aborted;
        c0      = cyc;
        snap_p  = m_pressed;
        aborted = 1'b0;
        rd      = '0;
        fill_mz(c0 + 4, 1'b0);
        spi_cs_i   = 1'b0;
        spi_mosi_i = (nbits > 0) ? mosi_w[nbits-1] : 1'b0;
        wait_cyc(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                fill_led(cyc + 1, 8'h00);
                fill_irq(cyc + 1, 1'b0);
                fill_mz(cyc + 1, 1'b1);
                m_pressed = '0;
                aborted   = 1'b1;
                rst_i     = 1'b1;
                wait_cyc(1);
                rst_i     = 1'b0;
            end
            spi_sck_i = 1'b1;
            rd        = {rd[30:0], spi_miso_o};
            wait_cyc(HALF);
            spi_sck_i  = 1'b0;
            spi_mosi_i = (i + 1 < nbits) ? mosi_w[nbits-2-i] : 1'b0;
            wait_cyc(HALF);
        end
        c_rise   = cyc;
        spi_cs_i = 1'b1;
        fill_mz(c_rise + 4, 1'b1);
        if (!aborted) begin
            if (nbits == LED_W) begin
                fill_led(c_rise + 4, mosi_w[7:0]);
                exp_frame[c_rise + 4] = 1'b1;
                m_pressed = m_pressed & ~snap_p;
                fill_irq(c_rise + 5, |m_pressed);
            end else begin
                exp_err[c_rise + 4] = 1'b1;
            end
            exp_rd = (nbits > 0) ? ((32'({snap_p, 4'b0000}) << 24) >> (32 - nbits)) : 32'd0;
            check("miso_read", rd, exp_rd);
        end
    endtask

    logic [31:0] rd;
    logic [31:0] glitch_exp;
    int          cr;

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_led[i]   = 8'h00;
            exp_frame[i] = 1'b0;
            exp_err[i]   = 1'b0;
            exp_irq[i]   = 1'b0;
            exp_mz[i]    = 1'b1;
        end
        rst_i      = 1'b1;
        spi_cs_i   = 1'b1;
        spi_sck_i  = 1'b0;
        spi_mosi_i = 1'b0;
        but_i      = '0;
        @(negedge clk);
        wait_cyc(3);
        rst_i = 1'b0;
        wait_cyc(12);

        // 1: reset state
        check("t1_led", 32'(led_o), 0);
        check("t1_miso", 32'(spi_miso_o), 0);
        check("t1_irq", 32'(irq_o), 0);

        // 2: plain frame, exact LED latency
        spi_frame(8, 32'hA5, -1, rd, cr);
        check("t2_read", rd, 32'h00);
        wait_cyc(3);
        check("t2_led_early", 32'(led_o), 32'h00);
        wait_cyc(1);
        check("t2_led", 32'(led_o), 32'hA5);
        check("t2_frame", 32'(frame_o), 1);
        wait_cyc(10);

        // 3: press, read-and-clear, reread empty
        press(2, 40);
        wait_cyc(30);
        check("t3_irq_set", 32'(irq_o), 1);
        spi_frame(8, 32'h5A, -1, rd, cr);
        check("t3_read", rd, 32'h40);
        wait_cyc(6);
        check("t3_irq_clr", 32'(irq_o), 0);
        wait_cyc(8);
        spi_frame(8, 32'hC3, -1, rd, cr);
        check("t3_reread", rd, 32'h00);
        wait_cyc(12);

        // 4: short, long and empty frames are errors and keep state
        press(1, 40);
        wait_cyc(30);
        spi_frame(5, 32'h1F, -1, rd, cr);
        wait_cyc(4);
        check("t4_err5", 32'(err_o), 1);
        wait_cyc(8);
        spi_frame(9, 32'h1FF, -1, rd, cr);
        wait_cyc(12);
        spi_frame(0, 32'h0, -1, rd, cr);
        wait_cyc(4);
        check("t4_err0", 32'(err_o), 1);
        check("t4_led_kept", 32'(led_o), 32'hC3);
        wait_cyc(8);
        spi_frame(8, 32'h66, -1, rd, cr);
        check("t4_reread", rd, 32'h20);
        wait_cyc(12);

        // 5: reset in the middle of a frame
        spi_frame(8, 32'h99, 3, rd, cr);
        wait_cyc(4);
        check("t5_led_rst", 32'(led_o), 32'h00);
        wait_cyc(8);
        spi_frame(8, 32'h3C, -1, rd, cr);
        wait_cyc(4);
        check("t5_led", 32'(led_o), 32'h3C);
        wait_cyc(8);

        // 6: short glitch on button 0
        press(0, 10);
        wait_cyc(40);
`ifdef SPI_IO_BTN_DEBOUNCE_EN
        glitch_exp = 32'h00;
`else
        glitch_exp = 32'h10;
`endif
        spi_frame(8, 32'h01, -1, rd, cr);
        check("t6_read", rd, glitch_exp);
        wait_cyc(12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
